lab4_branch_branch_gshare: RTL and testbench

Parametrised successor to the single-table global-history predictor. It supports configurable PHT depth, counter width, history length and index hashing (pure global or gshare PC-XOR-history). The table is initialised after reset by a multi-cycle sweep, and a ready output is raised when the sweep finishes. It sits in the fetch-stage branch unit, with prediction and update in the same cycle for the same PC.

---
 rtl/lab4_branch_pkg.sv | 32 +++
 rtl/lab4_branch_pht_sat.sv | 49 ++++
 rtl/lab4_branch_branch_gshare.sv | 125 ++++++++++++
 tb/tb_lab4_branch_branch_gshare.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/lab4_branch_pkg.sv
// Shared types, hash-mode constants and saturating-counter helper for the
// lab4 branch predictors.
package lab4_branch_pkg;

  // Predictor controller states
  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int unsigned HASH_GLOBAL   = 0;
  localparam int unsigned HASH_GSHARE   = 1;
  localparam int unsigned CTR_MAX_NBITS = 4;

  // Saturating up/down step of an nbits-wide counter (nbits <= CTR_MAX_NBITS)
  function automatic logic [CTR_MAX_NBITS-1:0] sat_ctr_next(
    input logic [CTR_MAX_NBITS-1:0] ctr,
    input logic                     taken,
    input int unsigned              nbits
  );
    logic [CTR_MAX_NBITS-1:0] ctr_max;
    logic [CTR_MAX_NBITS-1:0] result;
    ctr_max = CTR_MAX_NBITS'((32'd1 << nbits) - 32'd1);
    if (taken) begin
      result = (ctr == ctr_max) ? ctr : ctr + CTR_MAX_NBITS'(1);
    end else begin
      result = (ctr == '0) ? ctr : ctr - CTR_MAX_NBITS'(1);
    end
    return result;
  endfunction

endpackage

// File: rtl/lab4_branch_pht_sat.sv
// 1-read/1-write pattern history table of saturating counters. The write
// port either stores the init value (sweep) or the saturated successor of
// the entry currently being read (update).
module lab4_branch_pht_sat
  import lab4_branch_pkg::*;
#(
  parameter int unsigned DEPTH     = 2048,
  parameter int unsigned AW        = 11,
  parameter int unsigned CTR_NBITS = 2,
  parameter int unsigned CTR_INIT  = 1
) (
  input  logic                 clk,
  input  logic [AW-1:0]        idx,
  output logic [CTR_NBITS-1:0] rd_ctr,
  input  logic                 init_en,
  input  logic [AW-1:0]        init_idx,
  input  logic                 upd_en,
  input  logic                 upd_taken
);

  logic [CTR_NBITS-1:0] mem [DEPTH];
  logic                 wr_en;
  logic [AW-1:0]        wr_idx;
  logic [CTR_NBITS-1:0] wr_data;
  logic [CTR_NBITS-1:0] sat_data;

  // Asynchronous read: the current cycle sees the pre-write value
  assign rd_ctr = mem[idx];

  // Write-port selection between init sweep and saturating update
  always_comb begin
    sat_data = CTR_NBITS'(sat_ctr_next(CTR_MAX_NBITS'(rd_ctr), upd_taken, CTR_NBITS));
    wr_en    = init_en | upd_en;
    wr_idx   = idx;
    wr_data  = sat_data;
    if (init_en) begin
      wr_idx  = init_idx;
      wr_data = CTR_NBITS'(CTR_INIT);
    end
  end

  // Counter storage; contents are established by the init sweep, not reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/lab4_branch_branch_gshare.sv
// Parametrised global-history / gshare direction predictor with a
// post-reset PHT init sweep. Optional statistics counters are enabled by
// defining LAB4_BRANCH_GSHARE_STATS_EN.
module lab4_branch_branch_gshare
  import lab4_branch_pkg::*;
#(
  parameter int unsigned PHT_size     = 2048,
  parameter int unsigned CTR_NBITS    = 2,
  parameter int unsigned HIST_NBITS   = 11,
  parameter int unsigned HASH_MODE    = 1,
  parameter int unsigned CTR_INIT     = 1,
  parameter int unsigned c_addr_nbits = $clog2(PHT_size)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC,
  input  logic        update_en,
  input  logic        update_val,
  output logic        prediction,
`ifdef LAB4_BRANCH_GSHARE_STATS_EN
  output logic [31:0] num_updates,
  output logic [31:0] num_mispred,
`endif
  output logic        ready
);

  state_t                  state;
  logic [HIST_NBITS-1:0]   ghr;
  logic [HIST_NBITS-1:0]   ghr_next;
  logic [c_addr_nbits-1:0] init_ptr;
  logic [c_addr_nbits-1:0] hist_ext;
  logic [c_addr_nbits-1:0] idx;
  logic [CTR_NBITS-1:0]    rd_ctr;
  logic                    init_en;
  logic                    upd_fire;
  logic                    unused_pc;

  // Only the word-aligned index bits of PC feed the hash
  assign unused_pc = ^PC;

  // ---------------- Ctrl ----------------

  // Two-state controller: sweep the table, then serve predictions
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
    end else begin
      case (state)
        INIT:    if (init_ptr == c_addr_nbits'(PHT_size - 1)) state <= READY;
        READY:   state <= READY;
        default: state <= INIT;
      endcase
    end
  end

  // Write enables and output qualification
  always_comb begin
    init_en    = (state == INIT) && !reset;
    upd_fire   = (state == READY) && update_en && !reset;
    ready      = (state == READY);
    prediction = (state == READY) && rd_ctr[CTR_NBITS-1];
  end

  // ---------------- DPath ----------------

  // Index hash: history alone or PC xor history
  always_comb begin
    hist_ext = c_addr_nbits'(ghr);
    ghr_next = (ghr << 1) | HIST_NBITS'(update_val);
    if (HASH_MODE == HASH_GSHARE) begin
      idx = PC[c_addr_nbits+1:2] ^ hist_ext;
    end else begin
      idx = hist_ext;
    end
  end

  // Init sweep pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      init_ptr <= '0;
    end else if (state == INIT) begin
      init_ptr <= init_ptr + c_addr_nbits'(1);
    end
  end

  // Global history shifts in each accepted outcome, oldest bit dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      ghr <= '0;
    end else if (upd_fire) begin
      ghr <= ghr_next;
    end
  end

  lab4_branch_pht_sat #(
    .DEPTH     (PHT_size),
    .AW        (c_addr_nbits),
    .CTR_NBITS (CTR_NBITS),
    .CTR_INIT  (CTR_INIT)
  ) u_pht (
    .clk       (clk),
    .idx       (idx),
    .rd_ctr    (rd_ctr),
    .init_en   (init_en),
    .init_idx  (init_ptr),
    .upd_en    (upd_fire),
    .upd_taken (update_val)
  );

`ifdef LAB4_BRANCH_GSHARE_STATS_EN
  // Update and misprediction counters, frozen outside READY
  always_ff @(posedge clk) begin
    if (reset) begin
      num_updates <= '0;
      num_mispred <= '0;
    end else if (upd_fire) begin
      num_updates <= num_updates + 32'd1;
      if (prediction != update_val) begin
        num_mispred <= num_mispred + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lab4_branch_branch_gshare.sv
// Directed bench: one global-history instance (16 entries, 1-bit history)
// and one gshare instance (16 entries, 4-bit history).
module tb_lab4_branch_branch_gshare;

  logic clk = 1'b0;
  logic reset;

  logic [31:0] s_pc, g_pc;
  logic        s_en, s_val, g_en, g_val;
  logic        s_pred, s_rdy, g_pred, g_rdy;
`ifdef LAB4_BRANCH_GSHARE_STATS_EN
  logic [31:0] s_nu, s_nm, g_nu, g_nm;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lab4_branch_branch_gshare #(
    .PHT_size(16), .CTR_NBITS(2), .HIST_NBITS(1), .HASH_MODE(0), .CTR_INIT(1)
  ) dut_s (
    .clk(clk), .reset(reset), .PC(s_pc), .update_en(s_en), .update_val(s_val),
    .prediction(s_pred),
`ifdef LAB4_BRANCH_GSHARE_STATS_EN
    .num_updates(s_nu), .num_mispred(s_nm),
`endif
    .ready(s_rdy)
  );

  lab4_branch_branch_gshare #(
    .PHT_size(16), .CTR_NBITS(2), .HIST_NBITS(4), .HASH_MODE(1), .CTR_INIT(1)
  ) dut_g (
    .clk(clk), .reset(reset), .PC(g_pc), .update_en(g_en), .update_val(g_val),
    .prediction(g_pred),
`ifdef LAB4_BRANCH_GSHARE_STATS_EN
    .num_updates(g_nu), .num_mispred(g_nm),
`endif
    .ready(g_rdy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle reset, then sweep with updates requested; ready must rise after 16 edges
  task automatic reset_and_sweep(input string tag);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    s_en = 1'b1; s_val = 1'b1; g_en = 1'b1; g_val = 1'b1;
    for (int c = 0; c < 16; c++) begin
      #1;
      chk({tag, "_rdy0"}, {30'd0, s_rdy, g_rdy}, 32'd0);
      chk({tag, "_pred0"}, {30'd0, s_pred, g_pred}, 32'd0);
      @(negedge clk);
    end
    s_en = 1'b0; g_en = 1'b0;
    #1;
    chk({tag, "_rdy1"}, {30'd0, s_rdy, g_rdy}, 32'd3);
  endtask

  // Present an update on dut_s, check this cycle's prediction; edge applies it
  task automatic step_s(input logic val, input logic exp, input string tag);
    @(negedge clk);
    s_pc = 32'd0; s_en = 1'b1; s_val = val;
    #1;
    chk(tag, {31'd0, s_pred}, {31'd0, exp});
  endtask

  task automatic probe_s(input logic exp, input string tag);
    @(negedge clk);
    s_en = 1'b0;
    #1;
    chk(tag, {31'd0, s_pred}, {31'd0, exp});
  endtask

  task automatic step_g(input logic [31:0] pc, input logic val, input logic exp, input string tag);
    @(negedge clk);
    g_pc = pc; g_en = 1'b1; g_val = val;
    #1;
    chk(tag, {31'd0, g_pred}, {31'd0, exp});
  endtask

  task automatic probe_g(input logic [31:0] pc, input logic exp, input string tag);
    @(negedge clk);
    g_pc = pc; g_en = 1'b0;
    #1;
    chk(tag, {31'd0, g_pred}, {31'd0, exp});
  endtask

  initial begin
    reset = 1'b0;
    s_pc = 32'd0; s_en = 1'b0; s_val = 1'b0;
    g_pc = 32'd0; g_en = 1'b0; g_val = 1'b0;

    // Init sweep from power-up
    reset_and_sweep("init");
`ifdef LAB4_BRANCH_GSHARE_STATS_EN
    chk("stats_frozen_nu", s_nu, 32'd0);
    chk("stats_frozen_nm", s_nm, 32'd0);
`endif

    // Saturation on the 1-bit-history global instance
    step_s(1'b1, 1'b0, "sat_t1");
    step_s(1'b1, 1'b0, "sat_t2");
    step_s(1'b1, 1'b1, "sat_t3");
    step_s(1'b1, 1'b1, "sat_t4");
    step_s(1'b1, 1'b1, "sat_t5");
    step_s(1'b0, 1'b1, "sat_n1_nowrap");
    step_s(1'b0, 1'b1, "sat_n2");
    step_s(1'b0, 1'b0, "sat_n3");
    step_s(1'b0, 1'b0, "sat_n4");
    step_s(1'b0, 1'b0, "sat_n5");
    probe_s(1'b0, "sat_floor");
    step_s(1'b1, 1'b0, "sat_up_from0");
    probe_s(1'b1, "sat_p1_held");

    // GHR shift on gshare instance with PC=0 (idx = GHR): outcomes 1,0,1,1,0
    step_g(32'h0, 1'b1, 1'b0, "ghr_s1");
    step_g(32'h0, 1'b0, 1'b0, "ghr_s2");
    step_g(32'h0, 1'b1, 1'b0, "ghr_s3");
    step_g(32'h0, 1'b1, 1'b0, "ghr_s4");
    step_g(32'h0, 1'b0, 1'b0, "ghr_s5");
    // GHR now 0110; PHT[0]=2 PHT[1]=0 PHT[2]=2 PHT[5]=2 PHT[11]=0
    probe_g(32'h18, 1'b1, "ghr_probe_e0");
    probe_g(32'h10, 1'b1, "ghr_probe_e2");
    probe_g(32'h0C, 1'b1, "ghr_probe_e5");
    probe_g(32'h14, 1'b0, "ghr_probe_e3");
    probe_g(32'h1C, 1'b0, "ghr_probe_e1");

    // Reset mid-sweep at init cycle 7 must restart the full 16-cycle sweep
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 7; c++) @(negedge clk);
    #1;
    chk("mid_rdy_before", {30'd0, s_rdy, g_rdy}, 32'd0);
    reset_and_sweep("midrst");
`ifdef LAB4_BRANCH_GSHARE_STATS_EN
    chk("stats_rst_nu", s_nu, 32'd0);
    chk("stats_rst_nm", s_nm, 32'd0);
`endif

    // Gshare: drive GHR to 0101 with PC=0, then update at PC=0x30 -> entry 9
    step_g(32'h0, 1'b0, 1'b0, "gs_h1");
    step_g(32'h0, 1'b1, 1'b0, "gs_h2");
    step_g(32'h0, 1'b0, 1'b0, "gs_h3");
    step_g(32'h0, 1'b1, 1'b0, "gs_h4");
    step_g(32'h30, 1'b1, 1'b0, "gs_upd9");
    // GHR now 1011
    probe_g(32'h08, 1'b1, "gs_e9_written");
    probe_g(32'h1C, 1'b0, "gs_e12_untouched");
    probe_g(32'h38, 1'b0, "gs_e5_untouched");

    // Stats run on global instance: T,T,T,T,N,T,T,T -> 3 mispredictions
    step_s(1'b1, 1'b0, "st_u1");
    step_s(1'b1, 1'b0, "st_u2");
    step_s(1'b1, 1'b1, "st_u3");
    step_s(1'b1, 1'b1, "st_u4");
    step_s(1'b0, 1'b1, "st_u5");
    step_s(1'b1, 1'b1, "st_u6");
    step_s(1'b1, 1'b1, "st_u7");
    step_s(1'b1, 1'b1, "st_u8");
    probe_s(1'b1, "st_final_pred");
`ifdef LAB4_BRANCH_GSHARE_STATS_EN
    chk("stats_nu", s_nu, 32'd8);
    chk("stats_nm", s_nm, 32'd3);
    chk("stats_g_nu", g_nu, 32'd5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
